// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the FSM state encoding and the row one-hot decoder.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        EMIT     = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } kp_state_t;

    // Returns the index of the highest set bit; callers only pass one-hot vectors.
    function automatic int onehot_to_index(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting one-shot timer shared by all keypad FSM delays.
// A load of N makes expire pulse on the Nth cycle after the load cycle, then it rests at 0.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/keypad_scanner_fsm.sv
// Column-scanning keypad controller with press/release debounce and optional typematic repeat.
// Emits a one-cycle key_valid carrying row_idx*COLS + col_idx.
module keypad_scanner_fsm
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 1200,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 60000,
    parameter int REPEAT_PERIOD   = 12000,
    localparam int CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_drive,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_repeat,
    output logic              key_held,
    output logic              multi_key
);

    localparam int RW      = $clog2(ROWS);
    localparam int CW      = $clog2(COLS);
    localparam int DW      = $clog2(SCAN_DWELL);
    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    kp_state_t         state, next_state;
    logic [ROWS-1:0]   row_meta, row_s;
    logic [DW-1:0]     dwell;
    logic [RW-1:0]     row_idx;
    logic [CW-1:0]     col_idx;
    logic [31:0]       row_ext;
    logic [ROWS-1:0]   row_mask;
    logic              row_bit;
    logic              sample;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_value;
    logic              tmr_expire;
    logic              col_adv;
    logic              latch_key;
    logic              code_load;

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    assign row_ext   = 32'(row_s);
    assign row_mask  = ROWS'(1) << row_idx;
    assign row_bit   = row_s[row_idx];
    assign sample    = (dwell == DW'(SCAN_DWELL - 1));
    assign col_drive = COLS'(1) << col_idx;
    assign key_held  = (state == EMIT) || (state == HOLD) || (state == RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= '0;
            row_s    <= '0;
            state    <= SCAN;
            dwell    <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            key_code <= '0;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
            state    <= next_state;
            // Dwell restarts whenever scanning resumes so each column gets a full slot.
            if (state != SCAN || sample) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + DW'(1);
            end
            if (col_adv) begin
                col_idx <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
            end
            if (latch_key) begin
                row_idx <= RW'(onehot_to_index(row_ext));
            end
            if (code_load) begin
                key_code <= CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);
            end
        end
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        col_adv    = 1'b0;
        latch_key  = 1'b0;
        code_load  = 1'b0;
        key_valid  = 1'b0;
        key_repeat = 1'b0;
        multi_key  = 1'b0;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (row_s == '0) begin
                        col_adv = 1'b1;
                    end else if ($onehot(row_s)) begin
                        latch_key  = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_value  = TMR_W'(DEBOUNCE_CYCLES);
                        next_state = DEBOUNCE;
                    end else begin
                        multi_key = 1'b1;
                        col_adv   = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (row_s != row_mask) begin
                    col_adv    = 1'b1;
                    next_state = SCAN;
                end else if (tmr_expire) begin
                    code_load  = 1'b1;
                    next_state = EMIT;
                end
            end
            EMIT: begin
                key_valid  = 1'b1;
                tmr_load   = 1'b1;
                tmr_value  = TMR_W'(REPEAT_DELAY);
                next_state = HOLD;
            end
            HOLD: begin
                // A release seen on the same cycle as a repeat expiry wins; no repeat is emitted.
                if (!row_bit) begin
                    tmr_load   = 1'b1;
                    tmr_value  = TMR_W'(DEBOUNCE_CYCLES);
                    next_state = RELEASE;
                end else if (REPEAT_EN != 0 && tmr_expire) begin
                    key_valid  = 1'b1;
                    key_repeat = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_value  = TMR_W'(REPEAT_PERIOD);
                end
            end
            RELEASE: begin
                if (row_bit) begin
                    tmr_load   = 1'b1;
                    tmr_value  = TMR_W'(REPEAT_PERIOD);
                    next_state = HOLD;
                end else if (tmr_expire) begin
                    col_adv    = 1'b1;
                    next_state = SCAN;
                end
            end
            default: begin
                next_state = SCAN;
            end
        endcase
    end

endmodule
